// File: rtl/map_query_arbiter.sv
// Round-robin arbiter sharing one combinational wall Map among N movers; registered query, tagged 2-cycle response.
// Define MAPARB_PACMAN_PRIO_EN to give requester 0 (Pac-Man) absolute priority over the ghost round-robin.
module map_query_arbiter #(
  parameter int N_REQ = 4,
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  parameter int X_MAX = 640,
  parameter int Y_MAX = 480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*X_W-1:0] req_x,
  input  logic [N_REQ*Y_W-1:0] req_y,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic               rsp_wall,
  output logic [X_W-1:0]       map_x,
  output logic [Y_W-1:0]       map_y,
  input  logic               map_is_wall,
  output logic               busy
);
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] s1_id_q, s1_id_d;
  logic             s1_vld_q, s1_vld_d;
  logic             s1_oob_q, s1_oob_d;
  logic [X_W-1:0]   map_x_q, map_x_d;
  logic [Y_W-1:0]   map_y_q, map_y_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic             rsp_wall_q, rsp_wall_d;
  logic             busy_q, busy_d;

  logic             win_found;
  logic [PTR_W-1:0] win_id;
  logic [N_REQ-1:0] grant_c;
  logic [X_W-1:0]   win_x;
  logic [Y_W-1:0]   win_y;
  int               srch;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    srch      = 0;
`ifdef MAPARB_PACMAN_PRIO_EN
    if (req[0]) begin
      win_found = 1'b1;
    end else begin
      // ghost ring covers 1..N_REQ-1; a pointer of 0 starts the search at 1
      for (int k = 0; k < N_REQ - 1; k++) begin
        srch = ((ptr_q == '0) ? 1 : int'(ptr_q)) + k;
        if (srch > N_REQ - 1) srch = srch - (N_REQ - 1);
        if (!win_found && req[PTR_W'(srch)]) begin
          win_found = 1'b1;
          win_id    = PTR_W'(srch);
        end
      end
    end
`else
    for (int k = 0; k < N_REQ; k++) begin
      srch = int'(ptr_q) + k;
      if (srch >= N_REQ) srch = srch - N_REQ;
      if (!win_found && req[PTR_W'(srch)]) begin
        win_found = 1'b1;
        win_id    = PTR_W'(srch);
      end
    end
`endif
  end

  always_comb begin
    grant_c = '0;
    win_x   = '0;
    win_y   = '0;
    if (win_found) grant_c = N_REQ'(1) << win_id;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_c[i]) begin
        win_x = req_x[i*X_W +: X_W];
        win_y = req_y[i*Y_W +: Y_W];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    map_x_d     = map_x_q;
    map_y_d     = map_y_q;
    s1_id_d     = s1_id_q;
    s1_vld_d    = win_found;
    s1_oob_d    = 1'b0;
    rsp_valid_d = '0;
    rsp_wall_d  = rsp_wall_q;

`ifdef MAPARB_PACMAN_PRIO_EN
    if (win_found && win_id != '0)
`else
    if (win_found)
`endif
      ptr_d = (win_id == PTR_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;

    if (win_found) begin
      map_x_d  = win_x;
      map_y_d  = win_y;
      s1_id_d  = win_id;
      // coordinates arrive pre-offset and may have wrapped; anything off-screen reads as wall
      s1_oob_d = (32'(win_x) >= X_MAX) || (32'(win_y) >= Y_MAX);
    end

    if (s1_vld_q) begin
      rsp_valid_d = N_REQ'(1) << s1_id_q;
      rsp_wall_d  = s1_oob_q | map_is_wall;
    end

    busy_d = s1_vld_d | s1_vld_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      s1_id_q     <= '0;
      s1_vld_q    <= 1'b0;
      s1_oob_q    <= 1'b0;
      map_x_q     <= '0;
      map_y_q     <= '0;
      rsp_valid_q <= '0;
      rsp_wall_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      s1_id_q     <= s1_id_d;
      s1_vld_q    <= s1_vld_d;
      s1_oob_q    <= s1_oob_d;
      map_x_q     <= map_x_d;
      map_y_q     <= map_y_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_wall_q  <= rsp_wall_d;
      busy_q      <= busy_d;
    end
  end

  assign grant     = grant_c;
  assign map_x     = map_x_q;
  assign map_y     = map_y_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wall  = rsp_wall_q;
  assign busy      = busy_q;

endmodule

// File: doc/map_query_arbiter.md
Name: map_query_arbiter

Overview:
- Shares the single combinational wall-lookup Map among N movers (Pac-Man plus ghosts). Each mover requests a wall check at a candidate (x, y).
- Round-robin arbitration grants at most one query per clock. Query coordinates are registered into the Map, and the wall result is returned to the winner as a tagged, registered response.
- Sits between the mover FSMs and the Map instance. Removes the need for one Map copy per mover.

Parameters:
- N_REQ, 4, number of requesters; index 0 is Pac-Man by convention, 1..N_REQ-1 are ghosts.
- X_W, 10, x coordinate width.
- Y_W, 9, y coordinate width.
- X_MAX, 640, first out-of-range x value.
- Y_MAX, 480, first out-of-range y value.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester query request, level.
- req_x  in  N_REQ*X_W  packed x; requester i occupies bits [i*X_W +: X_W].
- req_y  in  N_REQ*Y_W  packed y; requester i occupies bits [i*Y_W +: Y_W].
- grant  out  N_REQ  one-hot or zero; combinational; query accepted this cycle.
- rsp_valid  out  N_REQ  one-hot or zero; registered; one-cycle response pulse.
- rsp_wall  out  1  registered wall result; valid only while rsp_valid is nonzero.
- map_x  out  X_W  registered query x driven to the Map.
- map_y  out  Y_W  registered query y driven to the Map.
- map_is_wall  in  1  combinational Map result for (map_x, map_y).
- busy  out  1  registered; a query is in stage 1 or stage 2.

Behaviour:
- Reset values (asynchronous assert, synchronous release):
  - rsp_valid=0, rsp_wall=0, map_x=0, map_y=0, busy=0.
  - RR pointer=0, all pipeline valid bits=0.
- Arbitration (cycle T):
  - Search req starting at the pointer index, upward with wrap to 0.
  - The first set bit wins; grant[w]=1 in the same cycle. grant=0 when req=0.
  - The pointer updates at the T edge to (w+1) mod N_REQ, and only when a grant occurs.
- Handshake:
  - A requester holds req and its coordinates stable until it sees grant.
  - Each cycle with req=1 and grant=1 counts as one accepted query.
  - A requester wanting exactly one query must drop req at the edge following grant.
- Stage 1 (edge ending T):
  - map_x, map_y ← winner coordinates.
  - s1_id ← w, s1_vld ← 1.
  - s1_oob ← (x ≥ X_MAX) or (y ≥ Y_MAX).
- Stage 2 (edge ending T+1):
  - rsp_wall ← s1_oob ? 1 : map_is_wall.
  - rsp_valid ← one-hot(s1_id) if s1_vld, else 0.
- Latency and throughput:
  - rsp_valid[w] is high during cycle T+2, for exactly one cycle.
  - One query per cycle, fully pipelined; there is no back-pressure on responses.
- Idle cycles:
  - map_x and map_y hold their last values.
  - rsp_valid=0; rsp_wall holds its last value (don't-care).
- busy = s1_vld OR stage-2 valid.
- Boundary conditions:
  - Width arithmetic: there is none. Movers supply already-offset coordinates, e.g. y-1 wrapping from 0 to 511. A wrapped value of 511 ≥ Y_MAX is reported as a wall; that is required behaviour.
  - A single requester holding req continuously gets a grant every cycle and one response per cycle.
  - With all N_REQ requesting, grants rotate strictly; each requester gets one grant per N_REQ cycles.
  - Reset during operation drops in-flight queries. No rsp_valid is produced for them after release.

Optional Feature:
- Macro: MAPARB_PACMAN_PRIO_EN.
- Defined:
  - req[0] always wins when set, regardless of the pointer.
  - When req[0]=0, the search covers 1..N_REQ-1 round-robin. The pointer only tracks ghost grants; a grant to 0 leaves the pointer unchanged.
- Undefined: pure round-robin over all N_REQ, as specified above.

Test Plan:
- Reset, then req=0001, (x,y)=(100,200), Map returns 1:
  - grant=0001 in cycle T.
  - map_x=100, map_y=200 in T+1.
  - rsp_valid=0001, rsp_wall=1 in T+2.
- req=1111 held for 8 cycles from reset (pointer 0):
  - grant sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000.
  - rsp_valid follows the same sequence delayed by 2 cycles.
- req[2] with y=511:
  - rsp_valid=0100 and rsp_wall=1 two cycles after grant, even while the Map stub drives 0.
  - Repeat with x=640: same result.
- Pulse rst for one cycle while two queries are in flight:
  - rsp_valid stays 0 and busy=0 until a new grant.
  - After release, req=0010 is granted first with the pointer reset to 0.
- With MAPARB_PACMAN_PRIO_EN defined, req=1111 for 4 cycles:
  - grant=0001 every cycle.
  - Then req=1110 gives grants 0010, 0100, 1000.
- Back-to-back single requester, req[3]=1 for 3 cycles with distinct coordinates and Map results 0, 1, 0:
  - Three consecutive rsp_valid=1000 pulses with rsp_wall 0, 1, 0.
